// File: rtl/xm_branch_pkg.sv
// rtl/xm_branch_pkg.sv - shared types and offset widths for the XMakina branch sequencer
package xm_branch_pkg;

    typedef enum logic [2:0] {
        COND_BEQ = 3'd0,
        COND_BNE = 3'd1,
        COND_BHS = 3'd2,
        COND_BLO = 3'd3,
        COND_BN  = 3'd4,
        COND_BGE = 3'd5,
        COND_BLT = 3'd6,
        COND_BAL = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_C = 2'd0,
        ST_Z = 2'd1,
        ST_N = 2'd2,
        ST_V = 2'd3
    } status_bit_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int COND_OFF_W = 10;
    localparam int LINK_OFF_W = 13;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch-condition evaluator (status flags, cond -> result)
module branch_cond_eval
    import xm_branch_pkg::*;
(
    input  logic [3:0] status,
    input  logic [2:0] cond,
    output logic       result
);

    always_comb begin
        result = 1'b0;
        case (cond_e'(cond))
            COND_BEQ: result = status[ST_Z];
            COND_BNE: result = ~status[ST_Z];
            COND_BHS: result = status[ST_C];
            COND_BLO: result = ~status[ST_C];
            COND_BN:  result = status[ST_N];
            COND_BGE: result = ~(status[ST_N] ^ status[ST_V]);
            COND_BLT: result = status[ST_N] ^ status[ST_V];
            COND_BAL: result = 1'b1;
            default:  result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle branch controller, decode to PC write-back
// Optional link-register write enabled by defining BRANCH_LINK_EN.
module branch_sequencer
    import xm_branch_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int OFF_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       branch_cond,
    input  logic             link,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  pc,
    input  logic [3:0]       status,
    output logic             busy,
    output logic             taken,
    output logic [PC_W-1:0]  pc_next,
    output logic             pc_we,
    output logic             lr_we,
    output logic [PC_W-1:0]  lr_data,
    output logic             done
);

    state_e            state_q, state_d;
    logic [2:0]        cond_q, cond_d;
    logic              link_q, link_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken_q, taken_d;
    logic [PC_W-1:0]   pc_next_q, pc_next_d;
    logic [PC_W-1:0]   lr_data_q, lr_data_d;
    logic              busy_q, busy_d;
    logic              pc_we_q, pc_we_d;
    logic              lr_we_q, lr_we_d;
    logic              done_q, done_d;

    logic              link_sel;
    logic              cond_result;
    logic              eval_taken;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   pc_target;

`ifdef BRANCH_LINK_EN
    assign link_sel = link;
`else
    logic unused_link;
    assign unused_link = link;
    assign link_sel    = 1'b0;
`endif

    branch_cond_eval u_cond_eval (
        .status (status),
        .cond   (cond_q),
        .result (cond_result)
    );

    assign eval_taken = cond_result | link_q;

    // Conditional branches carry a 10-bit word offset; branch-with-link uses the full 13 bits.
    assign off_ext   = link_q
                     ? {{(PC_W-LINK_OFF_W){offset_q[LINK_OFF_W-1]}}, offset_q[LINK_OFF_W-1:0]}
                     : {{(PC_W-COND_OFF_W){offset_q[COND_OFF_W-1]}}, offset_q[COND_OFF_W-1:0]};
    assign pc_target = pc_q + (off_ext << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cond_q    <= '0;
            link_q    <= 1'b0;
            offset_q  <= '0;
            pc_q      <= '0;
            taken_q   <= 1'b0;
            pc_next_q <= '0;
            lr_data_q <= '0;
            busy_q    <= 1'b0;
            pc_we_q   <= 1'b0;
            lr_we_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            link_q    <= link_d;
            offset_q  <= offset_d;
            pc_q      <= pc_d;
            taken_q   <= taken_d;
            pc_next_q <= pc_next_d;
            lr_data_q <= lr_data_d;
            busy_q    <= busy_d;
            pc_we_q   <= pc_we_d;
            lr_we_q   <= lr_we_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EVAL;
            S_EVAL:  state_d = eval_taken ? S_CALC : S_DONE;
            S_CALC:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each strobe is a flop aligned with its state.
    always_comb begin
        cond_d    = cond_q;
        link_d    = link_q;
        offset_d  = offset_q;
        pc_d      = pc_q;
        taken_d   = taken_q;
        pc_next_d = pc_next_q;
        lr_data_d = lr_data_q;
        busy_d    = (state_d != S_IDLE);
        pc_we_d   = (state_d == S_WRITE);
        lr_we_d   = (state_d == S_WRITE) && link_q;
        done_d    = (state_d == S_DONE);
        if (state_q == S_IDLE && start) begin
            cond_d   = branch_cond;
            link_d   = link_sel;
            offset_d = offset;
            pc_d     = pc;
        end
        if (state_q == S_EVAL) taken_d = eval_taken;
        if (state_q == S_CALC) begin
            pc_next_d = pc_target;
            if (link_q) lr_data_d = pc_q;
        end
    end

    assign busy    = busy_q;
    assign taken   = taken_q;
    assign pc_next = pc_next_q;
    assign pc_we   = pc_we_q;
    assign lr_we   = lr_we_q;
    assign lr_data = lr_data_q;
    assign done    = done_q;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle controller that sequences one branch instruction of the XMakina core from decode to PC write-back. It accepts a decoded branch request from the control unit, samples the processor status flags, evaluates the branch condition, computes the word-aligned target address and issues a single PC write strobe when the branch is taken. It sits between the control unit FSM, the status register and the PC register, and owns the branch-condition evaluator.

## Interface
Parameters:
- `PC_W`, 16, PC/address width.
- `OFF_W`, 13, width of raw offset field from decode.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe from control unit; accepted only in IDLE.
- `branch_cond`  in  3  condition code: BEQ, BNE, BHS, BLO, BN, BGE, BLT, BAL = 0..7.
- `link`  in  1  branch-with-link request; forces BAL semantics.
- `offset`  in  OFF_W  raw word offset from instruction.
- `pc`  in  PC_W  current (already incremented) PC.
- `status`  in  4  flags {V,N,Z,C}, bit0 = C, bit1 = Z, bit2 = N, bit3 = V.
- `busy`  out  1  high from the cycle after accept until `done`.
- `taken`  out  1  registered condition result, valid from CALC through DONE.
- `pc_next`  out  PC_W  computed target.
- `pc_we`  out  1  one-cycle PC write strobe.
- `lr_we`, `lr_data`  out  1 / PC_W  link-register write (see Configuration).
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, EVAL, CALC, WRITE, DONE.
- IDLE: on `start`=1, register `branch_cond`, `link`, `offset`, `pc`; go EVAL. `start` outside IDLE is ignored.
- EVAL: sample `status` (live input this cycle); compute condition: BEQ Z, BNE !Z, BHS C, BLO !C, BN N, BGE !(N^V), BLT N^V, BAL 1; `link`=1 forces taken. Register `taken`. Taken -> CALC, else -> DONE.
- CALC: `pc_next` = pc + (sext(off) << 1), modulo 2^PC_W (wraps, no carry out). `off` = offset[9:0] sign-extended when `link`=0; full offset[12:0] sign-extended when `link`=1. -> WRITE.
- WRITE: `pc_we`=1 for exactly this cycle; -> DONE.
- DONE: `done`=1 for one cycle; -> IDLE.
- Not-taken: `pc_we` never asserts; `pc_next` holds its previous value.

## Timing
- Reset (async, any state): state = IDLE; `busy`, `taken`, `pc_we`, `lr_we`, `done` = 0; `pc_next`, `lr_data` = 0. Reset mid-operation abandons the branch with no write strobes.
- `start` accepted at edge T. Taken: EVAL T+1, CALC T+2, `pc_we` at T+3, `done` at T+4. Not taken: EVAL T+1, `done` at T+2.
- `busy` high from T+1 through the `done` cycle inclusive; a new `start` is accepted in the cycle after `done`.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `BRANCH_LINK_EN` defined: when `link`=1 and taken, `lr_we`=1 in WRITE together with `pc_we`, `lr_data` = registered `pc`.
- Not defined: `link` input ignored (treated as 0, offset uses [9:0]); `lr_we` and `lr_data` tied to 0.

## Structure
- Shared package `xm_branch_pkg`: condition-code enum, status bit index enum (C, Z, N, V), FSM state enum, conditional/link offset widths.
- One sub-module: `branch_cond_eval`, purely combinational (status, cond -> result), instantiated in EVAL path.

## Test plan
- BEQ, Z=1, pc=0x1000, offset=0x004 -> `taken`=1, `pc_next`=0x1008, `pc_we` at T+3, `done` at T+4.
- BNE, Z=1 -> `taken`=0, `done` at T+2, `pc_we` never asserts, `busy` 2 cycles.
- BLT, N=1 V=0, pc=0x0010, offset=0x3FE (-2) -> `pc_next`=0x000C; same with N=1 V=1 -> not taken.
- BAL, pc=0xFFFE, offset=0x001 -> `pc_next`=0x0000 (wrap).
- `start` pulsed during CALC -> ignored, single `done`; `rst_n` low during CALC -> all outputs 0 immediately, IDLE, no `pc_we`.
- With `BRANCH_LINK_EN`: link=1, pc=0x2000, offset=0x1FFF (-1) -> `pc_next`=0x1FFE, `lr_we`=`pc_we`=1 at T+3, `lr_data`=0x2000.
